mem_arbiter: RTL and testbench

//  Shares the single-port memory between NUM_REQ requesters (port 0 = fetch, port 1 = load/store).

---
 rtl/mem_arbiter_pkg.sv | 9 +
 rtl/mem_arbiter_rr.sv | 36 +++
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared widths, defaults and state type for the memory arbiter
package mem_arbiter_pkg;
    localparam int ADDR_SIZE       = 32;
    localparam int WD_SIZE         = 32;
    localparam int MEM_ARB_NUM_REQ = 2;
    localparam int MEM_LATENCY     = 2;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
endpackage

// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - combinational round-robin pick starting after last_grant
module rr_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ = MEM_ARB_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] sel;
        idx      = 0;
        sel      = '0;
        grant    = '0;
        grant_id = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = int'(last_grant) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = idx[ID_W-1:0];
            if (req[sel]) begin
                grant      = '0;
                grant[sel] = 1'b1;
                grant_id   = sel;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin sharing of a single-port memory, one access in flight
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ = MEM_ARB_NUM_REQ,
    parameter int LATENCY = MEM_LATENCY,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0][ADDR_SIZE-1:0]  req_addr,
    input  logic [NUM_REQ-1:0]                 req_rd_wr,
    input  logic [NUM_REQ-1:0][WD_SIZE-1:0]    req_wr_data,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic [WD_SIZE-1:0]                 rsp_rd_data,
    output logic [ADDR_SIZE-1:0]               mem_addr,
    output logic                               mem_rd_wr,
    output logic                               mem_op_en,
    output logic [WD_SIZE-1:0]                 mem_wr_data,
    input  logic [WD_SIZE-1:0]                 mem_rd_data
);

    localparam int CNT_W = $clog2(LATENCY + 1);

    arb_state_t           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ID_W-1:0]      last_q, last_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic                 rd_wr_q, rd_wr_d;
    logic [WD_SIZE-1:0]   wr_data_q, wr_data_d;
    logic [WD_SIZE-1:0]   rsp_data_q, rsp_data_d;
    logic [NUM_REQ-1:0]   grant;
    logic [ID_W-1:0]      grant_id;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
        .req        (req_valid),
        .last_grant (last_q),
        .grant      (grant),
        .grant_id   (grant_id)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        id_d       = id_q;
        addr_d     = addr_q;
        rd_wr_d    = rd_wr_q;
        wr_data_d  = wr_data_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    id_d      = grant_id;
                    addr_d    = req_addr[grant_id];
                    rd_wr_d   = req_rd_wr[grant_id];
                    wr_data_d = req_wr_data[grant_id];
                    cnt_d     = CNT_W'(LATENCY - 1);
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    rsp_data_d = rd_wr_q ? '0 : mem_rd_data;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                last_d  = id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Async reset aborts any access in flight; the response is never issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= ID_W'(NUM_REQ - 1);
            id_q       <= '0;
            addr_q     <= '0;
            rd_wr_q    <= 1'b0;
            wr_data_q  <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            rd_wr_q    <= rd_wr_d;
            wr_data_q  <= wr_data_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign req_ready   = (state_q == IDLE) ? grant : '0;
    assign mem_op_en   = (state_q == ACCESS);
    assign mem_addr    = mem_op_en ? addr_q : '0;
    assign mem_rd_wr   = mem_op_en & rd_wr_q;
    assign mem_wr_data = mem_op_en ? wr_data_q : '0;
    assign rsp_rd_data = (state_q == RESP) ? rsp_data_q : '0;

    always_comb begin
        rsp_valid = '0;
        if (state_q == RESP) begin
            rsp_valid[id_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a transaction-level model
module tb_mem_arbiter;

    localparam int LAT = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req_valid, req_rd_wr;
    logic [1:0][31:0] req_addr, req_wr_data;

    logic [1:0]  req_ready, rsp_valid;
    logic [31:0] rsp_rd_data, mem_addr, mem_wr_data, mem_rd_data;
    logic        mem_rd_wr, mem_op_en;

    logic [1:0]  s1_req_ready, s1_rsp_valid, s4_req_ready, s4_rsp_valid;
    logic [31:0] s1_rsp_rd_data, s1_mem_addr, s1_mem_wr_data, s1_mem_rd_data;
    logic [31:0] s4_rsp_rd_data, s4_mem_addr, s4_mem_wr_data, s4_mem_rd_data;
    logic        s1_mem_rd_wr, s1_mem_op_en, s4_mem_rd_wr, s4_mem_op_en;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic        mem_clr;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int mdl_last = 1;
    int acc_log[$];
    int port_log[$];

    mem_arbiter #(.NUM_REQ(2), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_rd_wr(req_rd_wr), .req_wr_data(req_wr_data),
        .rsp_valid(rsp_valid), .rsp_rd_data(rsp_rd_data), .mem_addr(mem_addr),
        .mem_rd_wr(mem_rd_wr), .mem_op_en(mem_op_en), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    mem_arbiter #(.NUM_REQ(2), .LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(s1_req_ready),
        .req_addr(req_addr), .req_rd_wr(req_rd_wr), .req_wr_data(req_wr_data),
        .rsp_valid(s1_rsp_valid), .rsp_rd_data(s1_rsp_rd_data), .mem_addr(s1_mem_addr),
        .mem_rd_wr(s1_mem_rd_wr), .mem_op_en(s1_mem_op_en), .mem_wr_data(s1_mem_wr_data),
        .mem_rd_data(s1_mem_rd_data)
    );

    mem_arbiter #(.NUM_REQ(2), .LATENCY(4)) dut_l4 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(s4_req_ready),
        .req_addr(req_addr), .req_rd_wr(req_rd_wr), .req_wr_data(req_wr_data),
        .rsp_valid(s4_rsp_valid), .rsp_rd_data(s4_rsp_rd_data), .mem_addr(s4_mem_addr),
        .mem_rd_wr(s4_mem_rd_wr), .mem_op_en(s4_mem_op_en), .mem_wr_data(s4_mem_wr_data),
        .mem_rd_data(s4_mem_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (mem_op_en && mem_rd_wr) begin
            mem[mem_addr[7:0]] <= mem_wr_data;
        end
    end
    assign mem_rd_data    = mem[mem_addr[7:0]];
    assign s1_mem_rd_data = ~s1_mem_addr;
    assign s4_mem_rd_data = ~s4_mem_addr;

    task automatic idle_cycles(input int n);
        req_valid = 2'b00;
        repeat (n) @(negedge clk);
    endtask

    task automatic single_txn(input logic p, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, output int t_acc, output int t_rsp,
                              output logic [31:0] rd);
        t_acc = -1;
        t_rsp = -1;
        rd    = '0;
        req_addr[p]    = a;
        req_wr_data[p] = d;
        req_rd_wr[p]   = wr;
        req_valid[p]   = 1'b1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (req_ready[p]) begin
                t_acc = cyc;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        req_valid[p] = 1'b0;
        if (t_acc >= 0) begin
            mdl_last = int'(p);
            if (wr) ref_mem[a[7:0]] = d;
        end
        for (int k = 0; k < 20; k++) begin
            #1;
            if (rsp_valid[p]) begin
                t_rsp = cyc;
                rd    = rsp_rd_data;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    // Model: arbiter is free from accept+LAT+2, winner is the first valid port after the last
    // winner, response arrives at accept+LAT+1 carrying the model memory contents.
    task automatic run_traffic(input int ncyc, input int pct0, input int pct1, input bit drop_ok);
        logic [1:0]  v, exp_ready, exp_rsp;
        logic [31:0] a[2], d[2];
        logic        w[2];
        logic        win, rsp_port;
        logic [31:0] rsp_exp;
        int          pct[2];
        int          busy_until, rsp_due;
        bit          done;
        v = 2'b00; a = '{32'h0, 32'h0}; d = '{32'h0, 32'h0}; w = '{1'b0, 1'b0};
        pct[0] = pct0; pct[1] = pct1;
        busy_until = cyc; rsp_due = -1; rsp_port = 1'b0; rsp_exp = '0; done = 0; win = 1'b0;
        for (int k = 0; k < ncyc + 60; k++) begin
            if (k >= ncyc && v == 2'b00 && cyc >= busy_until) begin
                done = 1;
                break;
            end
            for (int p = 0; p < 2; p++) begin
                if (v[p]) begin
                    if (drop_ok && $urandom_range(7) == 0) v[p] = 1'b0;
                end else if (k < ncyc && $urandom_range(99) < pct[p]) begin
                    v[p] = 1'b1;
                    a[p] = 32'($urandom_range(15)) << 2;
                    w[p] = 1'($urandom_range(1));
                    d[p] = $urandom;
                end
            end
            req_valid   = v;
            req_addr    = {a[1], a[0]};
            req_wr_data = {d[1], d[0]};
            req_rd_wr   = {w[1], w[0]};
            #1;
            exp_ready = 2'b00;
            if (cyc >= busy_until && v != 2'b00) begin
                win = (mdl_last == 0);
                if (!v[win]) win = ~win;
                exp_ready = 2'b01 << win;
            end
            n_checks++;
            if (req_ready !== exp_ready)
                $display("FAIL traffic_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready);
            else n_pass++;
            exp_rsp = (cyc == rsp_due) ? (2'b01 << rsp_port) : 2'b00;
            n_checks++;
            if (rsp_valid !== exp_rsp)
                $display("FAIL traffic_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rsp);
            else n_pass++;
            if (cyc == rsp_due) begin
                n_checks++;
                if (rsp_rd_data !== rsp_exp)
                    $display("FAIL traffic_rsp_data cyc=%0d got=%h exp=%h", cyc, rsp_rd_data, rsp_exp);
                else n_pass++;
            end
            if (exp_ready != 2'b00) begin
                busy_until = cyc + LAT + 2;
                rsp_due    = cyc + LAT + 1;
                rsp_port   = win;
                if (w[win]) begin
                    ref_mem[a[win][7:0]] = d[win];
                    rsp_exp = '0;
                end else begin
                    rsp_exp = ref_mem[a[win][7:0]];
                end
                mdl_last = int'(win);
                v[win]   = 1'b0;
                acc_log.push_back(cyc);
                port_log.push_back(int'(win));
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        n_checks++;
        if (!done) $display("FAIL traffic_timeout got=pending exp=drained");
        else n_pass++;
    endtask

    task automatic test_reset;
        reset = 1'b1; mem_clr = 1'b1;
        req_valid = '0; req_rd_wr = '0; req_addr = '0; req_wr_data = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        repeat (2) @(negedge clk);
        mem_clr = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, mem_op_en, mem_rd_wr} !== 6'b0)
            $display("FAIL reset_ctrl got=%b exp=0", {req_ready, rsp_valid, mem_op_en, mem_rd_wr});
        else n_pass++;
        n_checks++;
        if ({mem_addr, mem_wr_data, rsp_rd_data} !== 96'b0)
            $display("FAIL reset_data got=%h exp=0", {mem_addr, mem_wr_data, rsp_rd_data});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        mdl_last = 1;
    endtask

    task automatic test_reset_abort;
        int          ta, tr;
        logic [31:0] rd;
        bit          seen;
        idle_cycles(3);
        req_addr[0] = 32'h20; req_rd_wr[0] = 1'b0; req_valid = 2'b01;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) $display("FAIL abort_accept got=%b exp=01", req_ready);
        else n_pass++;
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        n_checks++;
        if ({mem_op_en, mem_addr} !== {1'b1, 32'h20})
            $display("FAIL abort_op_on got=%b/%h exp=1/00000020", mem_op_en, mem_addr);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if (mem_op_en !== 1'b0) $display("FAIL abort_op_drop got=%b exp=0", mem_op_en);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        mdl_last = 1;
        seen = 0;
        repeat (6) begin
            #1;
            if (rsp_valid != 2'b00) seen = 1;
            @(negedge clk);
        end
        n_checks++;
        if (seen) $display("FAIL abort_no_rsp got=rsp exp=none");
        else n_pass++;
        single_txn(1'b1, 1'b0, 32'h24, 32'h0, ta, tr, rd);
        n_checks++;
        if (ta < 0 || tr - ta != LAT + 1)
            $display("FAIL abort_next_latency got=%0d exp=%0d", tr - ta, LAT + 1);
        else n_pass++;
        n_checks++;
        if (rd !== ref_mem[8'h24]) $display("FAIL abort_next_data got=%h exp=%h", rd, ref_mem[8'h24]);
        else n_pass++;
    endtask

    task automatic test_write_read;
        int          ta, tr;
        logic [31:0] rd;
        single_txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, ta, tr, rd);
        n_checks++;
        if (ta < 0 || tr - ta != 3) $display("FAIL wr_latency got=%0d exp=3", tr - ta);
        else n_pass++;
        n_checks++;
        if (rd !== 32'h0) $display("FAIL wr_rsp_data got=%h exp=0", rd);
        else n_pass++;
        single_txn(1'b0, 1'b0, 32'h10, 32'h0, ta, tr, rd);
        n_checks++;
        if (rd !== 32'hDEADBEEF) $display("FAIL rd_after_wr got=%h exp=deadbeef", rd);
        else n_pass++;
    endtask

    task automatic test_drop_before_grant;
        bit bad;
        int saw1;
        idle_cycles(3);
        req_addr = {32'h30, 32'h3C}; req_rd_wr = 2'b00; req_valid = 2'b10;
        #1;
        n_checks++;
        if (req_ready !== 2'b10) $display("FAIL drop_p1_accept got=%b exp=10", req_ready);
        else n_pass++;
        @(negedge clk);
        bad = 0; saw1 = -1;
        for (int i = 1; i <= 8; i++) begin
            req_valid = (i <= 2) ? 2'b01 : 2'b00;
            #1;
            if (req_ready[0] || rsp_valid[0] || (mem_op_en && mem_addr == 32'h3C)) bad = 1;
            if (rsp_valid[1]) saw1 = i;
            @(negedge clk);
        end
        n_checks++;
        if (bad) $display("FAIL drop_no_access got=access exp=none");
        else n_pass++;
        n_checks++;
        if (saw1 != 3) $display("FAIL drop_p1_rsp got=%0d exp=3", saw1);
        else n_pass++;
        req_addr = {32'h44, 32'h40}; req_valid = 2'b11;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) $display("FAIL drop_last_grant got=%b exp=01", req_ready);
        else n_pass++;
        @(negedge clk);
        idle_cycles(6);
        mdl_last = 0;
    endtask

    task automatic test_round_robin;
        bit ok;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mdl_last = 1;
        acc_log.delete();
        port_log.delete();
        run_traffic(20, 100, 100, 0);
        ok = (port_log.size() >= 4);
        for (int i = 0; i < 4 && ok; i++) if (port_log[i] != i % 2) ok = 0;
        n_checks++;
        if (!ok) $display("FAIL rr_order got=%p exp=0,1,0,1", port_log);
        else n_pass++;
    endtask

    task automatic test_single_port;
        bit ok;
        acc_log.delete();
        port_log.delete();
        run_traffic(30, 0, 100, 0);
        ok = (acc_log.size() >= 5);
        for (int i = 1; i < acc_log.size(); i++) begin
            if (acc_log[i] - acc_log[i-1] != LAT + 2 || port_log[i] != 1) ok = 0;
        end
        n_checks++;
        if (!ok) $display("FAIL single_port_spacing got=%p exp=step %0d", acc_log, LAT + 2);
        else n_pass++;
    endtask

    task automatic test_latency_sweep;
        logic [31:0] d;
        int          n1, n2, n4;
        bit          bad;
        idle_cycles(8);
        d = $urandom;
        req_addr[0] = 32'h5C; req_wr_data[0] = d; req_rd_wr[0] = 1'b1; req_valid = 2'b01;
        #1;
        n_checks++;
        if ({s1_req_ready, req_ready, s4_req_ready} !== 6'b010101)
            $display("FAIL sweep_accept got=%b exp=010101", {s1_req_ready, req_ready, s4_req_ready});
        else n_pass++;
        ref_mem[8'h5C] = d;
        mdl_last = 0;
        @(negedge clk);
        req_valid = 2'b00;
        n1 = 0; n2 = 0; n4 = 0; bad = 0;
        repeat (8) begin
            #1;
            if (s1_mem_op_en) begin
                n1++;
                if (s1_mem_addr !== 32'h5C || s1_mem_wr_data !== d || !s1_mem_rd_wr) bad = 1;
            end
            if (mem_op_en) begin
                n2++;
                if (mem_addr !== 32'h5C || mem_wr_data !== d || !mem_rd_wr) bad = 1;
            end
            if (s4_mem_op_en) begin
                n4++;
                if (s4_mem_addr !== 32'h5C || s4_mem_wr_data !== d || !s4_mem_rd_wr) bad = 1;
            end
            @(negedge clk);
        end
        n_checks++;
        if (n1 != 1) $display("FAIL sweep_width_l1 got=%0d exp=1", n1);
        else n_pass++;
        n_checks++;
        if (n2 != 2) $display("FAIL sweep_width_l2 got=%0d exp=2", n2);
        else n_pass++;
        n_checks++;
        if (n4 != 4) $display("FAIL sweep_width_l4 got=%0d exp=4", n4);
        else n_pass++;
        n_checks++;
        if (bad) $display("FAIL sweep_stable got=changed exp=stable");
        else n_pass++;
    endtask

    task automatic test_random;
        run_traffic(300, 40, 40, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_reset_abort();
        test_write_read();
        test_drop_before_grant();
        test_round_robin();
        test_single_port();
        test_latency_sweep();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
